// File: rtl/p_dff_arb.sv
// rtl/p_dff_arb.sv - round-robin arbiter/sequencer for a shared p_dff register bank (optional counters: PDFF_ARB_STATS_EN)
module p_dff_arb #(
  parameter int WORD     = 24,
  parameter int NSEL     = 5,
  parameter int NREQ     = 4,
  parameter int IDLE_MAX = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*NSEL-1:0]   prec,
  input  logic [NREQ*WORD-1:0]   data,
  output logic [NREQ-1:0]        gnt,
  output logic                   dff_en,
  output logic [NSEL-1:0]        dff_sel,
  output logic [WORD-1:0]        dff_d,
  output logic                   sleep
`ifdef PDFF_ARB_STATS_EN
  ,
  output logic [15:0]            grant_cnt,
  output logic [15:0]            sleep_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(IDLE_MAX);
  localparam logic [IW-1:0]   IDLE_LAST = IW'(IDLE_MAX - 1);
  localparam logic [NSEL-1:0] SEL_MAX   = NSEL'(WORD - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   idle, idle_n;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_n;
  logic            en_n;
  logic [NSEL-1:0] sel_n;
  logic [WORD-1:0] d_n;
  logic            found;
  logic [PW-1:0]   win;
  logic [NSEL-1:0] p_w;
  logic [WORD-1:0] d_w;

  // the current grantee still has req high this edge, so it sits out one round
  assign elig = (state == ACTIVE) ? (req & ~gnt) : '0;

  // rotating priority search starting at the round-robin pointer
  always_comb begin : pick
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign p_w = prec[int'(win)*NSEL +: NSEL];
  assign d_w = data[int'(win)*WORD +: WORD];

  // next state and next registered outputs; sel/d hold when nothing is granted
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idle_n  = idle;
    gnt_n   = '0;
    en_n    = 1'b0;
    sel_n   = dff_sel;
    d_n     = dff_d;
    case (state)
      ACTIVE: begin
        if (found) begin
          gnt_n  = NREQ'(1) << win;
          en_n   = 1'b1;
          d_n    = d_w;
          sel_n  = (int'(p_w) > WORD - 1) ? SEL_MAX : p_w;
          ptr_n  = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
          idle_n = '0;
        end else if (idle >= IDLE_LAST) begin
          state_n = SLEEP;
          idle_n  = '0;
        end else begin
          idle_n = idle + IW'(1);
        end
      end
      SLEEP: begin
        if (|req) state_n = WAKE;
      end
      WAKE: begin
        state_n = ACTIVE;
      end
      default: begin
        state_n = ACTIVE;
      end
    endcase
  end

  // state, pointer and all outputs are registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ACTIVE;
      ptr     <= '0;
      idle    <= '0;
      gnt     <= '0;
      dff_en  <= 1'b0;
      dff_sel <= '0;
      dff_d   <= '0;
      sleep   <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      idle    <= idle_n;
      gnt     <= gnt_n;
      dff_en  <= en_n;
      dff_sel <= sel_n;
      dff_d   <= d_n;
      sleep   <= (state_n == SLEEP);
    end
  end

`ifdef PDFF_ARB_STATS_EN
  // saturating grant and sleep-entry counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_cnt <= '0;
      sleep_cnt <= '0;
    end else begin
      if (en_n && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
      if (state == ACTIVE && state_n == SLEEP && sleep_cnt != 16'hFFFF)
        sleep_cnt <= sleep_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_p_dff_arb.sv
// tb/tb_p_dff_arb.sv - scoreboard bench for p_dff_arb
module tb_p_dff_arb;

  localparam int WORD = 24;
  localparam int NSEL = 5;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*NSEL-1:0] prec;
  logic [NREQ*WORD-1:0] data;
  logic [NREQ-1:0]      gnt;
  logic                 dff_en;
  logic [NSEL-1:0]      dff_sel;
  logic [WORD-1:0]      dff_d;
  logic                 sleep;
`ifdef PDFF_ARB_STATS_EN
  logic [15:0]          grant_cnt;
  logic [15:0]          sleep_cnt;
`endif

  p_dff_arb #(.WORD(WORD), .NSEL(NSEL), .NREQ(NREQ), .IDLE_MAX(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .prec      (prec),
    .data      (data),
    .gnt       (gnt),
    .dff_en    (dff_en),
    .dff_sel   (dff_sel),
    .dff_d     (dff_d),
    .sleep     (sleep)
`ifdef PDFF_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .sleep_cnt (sleep_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [3:0]  g;
    logic [4:0]  sel;
    logic [23:0] d;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  pv [4];
  logic [23:0] dv [4];
  int          base, c, g0, s, s4, t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input int r, input logic [4:0] sel);
    sbq.push_back('{at, 4'(1 << r), sel, dv[r]});
  endtask

  task automatic set_inputs();
    for (int r = 0; r < NREQ; r++) begin
      prec[r*NSEL +: NSEL] = pv[r];
      data[r*WORD +: WORD] = dv[r];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every presented grant must match the oldest expected grant
  always @(negedge clk) begin
    if (dff_en || gnt != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: gnt=%b dff_en=%b expected no grant at cycle %0d", gnt, dff_en, cyc);
      end else begin
        e = sbq.pop_front();
        chk("grant_cycle", 32'(cyc), 32'(e.at));
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("dff_en", 32'(dff_en), 32'd1);
        chk("dff_sel", 32'(dff_sel), 32'(e.sel));
        chk("dff_d", 32'(dff_d), 32'(e.d));
      end
    end
  end

  initial begin
    pv = '{5'd3, 5'd31, 5'd7, 5'd24};
    dv = '{24'h123456, 24'h654321, 24'hABCDEF, 24'h0F0F0F};
    set_inputs();
    reset_n = 1'b0;
    req     = 4'b1111;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_dff_en", 32'(dff_en), 32'd0);
    chk("rst_dff_sel", 32'(dff_sel), 32'd0);
    chk("rst_dff_d", 32'(dff_d), 32'd0);
    chk("rst_sleep", 32'(sleep), 32'd0);

    // release reset with all four requesting; each drops on its own grant
    base = cyc;
    reset_n = 1'b1;
    push(base + 1, 0, 5'd3);
    push(base + 2, 1, 5'd23);
    push(base + 3, 2, 5'd7);
    push(base + 4, 3, 5'd23);
    push(base + 5, 0, 5'd3);
    tick(); req = 4'b1110;
    tick(); req = 4'b1101;
    tick(); req = 4'b1011;
    tick(); req = 4'b0111;
    tick(); req = 4'b0000;

    // lone requester 2: granted every other cycle
    tick();
    c = cyc;
    req = 4'b0100;
    push(c + 1, 2, 5'd7);
    push(c + 3, 2, 5'd7);
    push(c + 5, 2, 5'd7);
    tick(); tick();
    chk("held_gnt", 32'(gnt), 32'd0);
    chk("held_en", 32'(dff_en), 32'd0);
    chk("held_sel", 32'(dff_sel), 32'd7);
    chk("held_d", 32'(dff_d), 32'hABCDEF);
    tick(); tick(); tick(); tick();

    // saturating precision, then precision 0
    c = cyc;
    req = 4'b0010;
    push(c + 1, 1, 5'd23);
    tick();
    pv[0] = 5'd0;
    set_inputs();
    req = 4'b0001;
    push(c + 2, 0, 5'd0);
    tick();
    req = 4'b0000;

    // idle into sleep, then wake with pointer preserved (ptr=1 -> 3 before 0)
    g0 = cyc;
    repeat (15) tick();
    chk("sleep_before", 32'(sleep), 32'd0);
    tick();
    chk("sleep_entered", 32'(sleep), 32'd1);
    chk("sleep_en", 32'(dff_en), 32'd0);
    chk("sleep_held_d", 32'(dff_d), 32'h123456);
    tick(); tick();
    s = cyc;
    req = 4'b1001;
    push(s + 3, 3, 5'd23);
    push(s + 4, 0, 5'd0);
    tick();
    chk("wake_sleep", 32'(sleep), 32'd0);
    tick(); tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;

    // request arriving on the idle-threshold edge wins over sleep
    s4 = cyc;
    repeat (15) tick();
    chk("thr_sleep_before", 32'(sleep), 32'd0);
    req = 4'b0100;
    push(s4 + 16, 2, 5'd7);
    tick();
    chk("thr_no_sleep", 32'(sleep), 32'd0);
    req = 4'b0000;

    // reset during a grant cycle: pointer back to 0, requester 1 re-granted
    tick();
    t = cyc;
    req = 4'b0010;
    push(t + 1, 1, 5'd23);
    tick();
    reset_n = 1'b0;
    req = 4'b0110;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_en", 32'(dff_en), 32'd0);
    chk("mid_rst_sel", 32'(dff_sel), 32'd0);
    chk("mid_rst_d", 32'(dff_d), 32'd0);
    reset_n = 1'b1;
    push(t + 3, 1, 5'd23);
    push(t + 4, 2, 5'd7);
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;

    repeat (4) tick();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
